// File: rtl/wide_word_serializer_pkg.sv
// Shared types and helpers for the wide-word to 32-bit stream serializer.
package wide_word_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int OUT_WIDTH_DEFAULT = 32;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/wide_word_serializer.sv
// Streams one wide input word as OUT_WIDTH-bit beats, LSB slice first, last beat zero-padded.
// Optional macro SERIALIZER_PREFETCH_EN: accept the next word on the final beat (no idle bubble).
module wide_word_serializer
    import wide_word_serializer_pkg::*;
#(
    parameter int IN_WIDTH  = 131,
    parameter int OUT_WIDTH = OUT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_WIDTH-1:0]  s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last
);

    localparam int BEATS  = ceil_div(IN_WIDTH, OUT_WIDTH);
    localparam int HOLD_W = BEATS * OUT_WIDTH;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    beat_reg, beat_next;
    logic [HOLD_W-1:0]   hold_reg, hold_next;
    logic [OUT_WIDTH-1:0] slices [BEATS];
    logic                last_beat;

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
            assign slices[gi] = hold_reg[gi*OUT_WIDTH +: OUT_WIDTH];
        end
    endgenerate

    assign last_beat = (beat_reg == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        hold_next  = hold_reg;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = '0;
        case (state_reg)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    // Zero-extension supplies the padding of the final beat.
                    hold_next  = HOLD_W'(s_data);
                    beat_next  = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                m_last  = last_beat;
                for (int i = 0; i < BEATS; i++) begin
                    if (beat_reg == CNT_W'(i)) begin
                        m_data = slices[i];
                    end
                end
`ifdef SERIALIZER_PREFETCH_EN
                s_ready = m_ready && last_beat;
`endif
                if (m_ready) begin
                    if (last_beat) begin
                        beat_next  = '0;
                        state_next = IDLE;
`ifdef SERIALIZER_PREFETCH_EN
                        if (s_valid) begin
                            hold_next  = HOLD_W'(s_data);
                            state_next = SEND;
                        end
`endif
                    end else begin
                        beat_next = beat_reg + CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Never advertise acceptance while reset is asserted.
        if (rst) begin
            s_ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_wide_word_serializer.sv
// Self-checking bench for wide_word_serializer (131-bit and 128-bit instances) with a beat scoreboard.
module tb_wide_word_serializer;

    localparam int W  = 131;
    localparam int OW = 32;
    localparam int NB = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, m_valid, m_ready, m_last;
    logic [W-1:0]  s_data;
    logic [OW-1:0] m_data;

    logic          s_valid2, s_ready2, m_valid2, m_ready2, m_last2;
    logic [127:0]  s_data2;
    logic [OW-1:0] m_data2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int word_count = 0;
    int last_count = 0;
    int last_hs_cyc = 0;
    logic last_sready = 1'b0;
    logic prev_last_sready = 1'b0;
    logic [32:0] exp_q [$];
    logic [159:0] mon_ext;
    logic [32:0]  mon_exp;

    wide_word_serializer #(.IN_WIDTH(W), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    wide_word_serializer #(.IN_WIDTH(128), .OUT_WIDTH(OW)) dut128 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard: expected beats pushed on input handshake, popped on output handshake.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (s_valid && s_ready) begin
                mon_ext = 160'(s_data);
                for (int b = 0; b < NB; b++) begin
                    exp_q.push_back({(b == NB - 1), mon_ext[b*OW +: OW]});
                end
                word_count++;
                $display("word %0d accepted at cycle %0d data=%h", word_count, cyc, s_data);
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got last=%b data=%h, required no beat", m_last, m_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({m_last, m_data} !== mon_exp) begin
                        errors++;
                        $display("FAIL beat_data: got last=%b data=%h, required last=%b data=%h",
                                 m_last, m_data, mon_exp[32], mon_exp[31:0]);
                    end
                end
                if (m_last) begin
                    last_count++;
                    prev_last_sready = last_sready;
                    last_sready = s_ready;
                    last_hs_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents a word and returns #1 after the accepting clock edge.
    task automatic send_word(input logic [W-1:0] d);
        bit ok;
        ok = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        s_data  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no s_ready, required accept within 200 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        s_valid2 = 1'b0; s_data2 = '0; m_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b required 0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b required 0", m_last); end
        checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data: got %h required 0", m_data); end
        rst = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_s_ready: got %b required 1", s_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        logic [W-1:0] w;
        int cnt;
        w = {3'b101, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        m_ready = 1'b1;
        send_word(w);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h11111111) begin
            errors++;
            $display("FAIL single_first_beat: got valid=%b data=%h required valid=1 data=11111111", m_valid, m_data);
        end
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!m_valid) break;
            cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (cnt != 5) begin errors++; $display("FAIL single_beat_count: got %0d required 5", cnt); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w;
        int cnt;
        w = {3'b101, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        m_ready = 1'b1;
        send_word(w);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (!m_valid) break;
            cnt++;
            m_ready = !(cnt >= 2 && cnt <= 4);
            if (cnt >= 2 && cnt <= 5) begin
                checks++;
                if (m_data !== 32'h22222222 || m_last !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold: got data=%h last=%b required data=22222222 last=0", m_data, m_last);
                end
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        checks++;
        if (cnt != 8) begin errors++; $display("FAIL stall_cycle_count: got %0d required 8", cnt); end
    endtask

    task automatic test_back_to_back();
        int t0, base, delta, exp_delta;
        logic exp_sready;
`ifdef SERIALIZER_PREFETCH_EN
        exp_delta = 10; exp_sready = 1'b1;
`else
        exp_delta = 11; exp_sready = 1'b0;
`endif
        m_ready = 1'b1;
        base = last_count;
        send_word({3'b011, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4});
        t0 = cyc;
        send_word({3'b110, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3, 32'hB4B4B4B4});
        for (int i = 0; i < 50; i++) begin
            if (last_count >= base + 2) break;
            @(posedge clk); #1;
        end
        delta = last_hs_cyc + 1 - t0;
        checks++;
        if (last_count != base + 2) begin errors++; $display("FAIL b2b_last_count: got %0d required %0d", last_count - base, 2); end
        checks++;
        if (delta != exp_delta) begin errors++; $display("FAIL b2b_cycles: got %0d required %0d", delta, exp_delta); end
        checks++;
        if (prev_last_sready !== exp_sready) begin
            errors++;
            $display("FAIL b2b_s_ready_on_last: got %b required %b", prev_last_sready, exp_sready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_word();
        m_ready = 1'b1;
        send_word({3'b001, 32'hC4C4C4C4, 32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1});
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (m_data !== 32'hC3C3C3C3) begin errors++; $display("FAIL midrst_beat2: got %h required c3c3c3c3", m_data); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid: got %b required 0", m_valid); end
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_s_ready_in_rst: got %b required 0", s_ready); end
        rst = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL midrst_s_ready_after: got %b required 1", s_ready); end
        @(posedge clk); #1;
        send_word({3'b111, 32'hD4D4D4D4, 32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1});
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'hD1D1D1D1) begin
            errors++;
            $display("FAIL midrst_next_first: got valid=%b data=%h required valid=1 data=d1d1d1d1", m_valid, m_data);
        end
        for (int i = 0; i < 20; i++) begin
            if (!m_valid) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_exact_multiple();
        logic [127:0] w;
        logic [31:0] ex;
        bit ok;
        w = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        m_ready2 = 1'b1;
        s_data2  = w;
        s_valid2 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_ready2) begin @(posedge clk); #1; ok = 1'b1; break; end
        end
        s_valid2 = 1'b0;
        s_data2  = '0;
        checks++;
        if (!ok) begin errors++; $display("FAIL exact_accept: got no s_ready, required accept"); end
        for (int b = 0; b < 4; b++) begin
            ex = w[b*32 +: 32];
            $display("exact beat %0d data=%h last=%b", b, m_data2, m_last2);
            checks++;
            if (m_valid2 !== 1'b1 || m_data2 !== ex || m_last2 !== (b == 3)) begin
                errors++;
                $display("FAIL exact_beat%0d: got valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                         b, m_valid2, m_data2, m_last2, ex, (b == 3));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (m_valid2 !== 1'b0) begin errors++; $display("FAIL exact_no_fifth: got m_valid=%b required 0", m_valid2); end
    endtask

    task automatic test_random();
        bit prod_done;
        int base_last, base_words;
        prod_done  = 1'b0;
        base_last  = last_count;
        base_words = word_count;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_word({$urandom, $urandom, $urandom, $urandom, $urandom});
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    m_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !m_valid) break;
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL random_drain: got %0d beats pending required 0", exp_q.size()); end
        checks++;
        if (word_count - base_words != 1000) begin errors++; $display("FAIL random_words: got %0d required 1000", word_count - base_words); end
        checks++;
        if (last_count - base_last != 1000) begin errors++; $display("FAIL random_last_count: got %0d required 1000", last_count - base_last); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_exact_multiple();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
